// File: rtl/acc_bus_ctrl_pkg.sv
// Shared types and constants for the accumulator bus controller.
// State encoding and operation codes are used by the top and its testbench.
package acc_bus_ctrl_pkg;

  typedef enum logic [2:0] {
    StInit = 3'd0,
    StClr  = 3'd1,
    StTurn = 3'd2,
    StIdle = 3'd3,
    StWr   = 3'd4,
    StRd   = 3'd5
  } state_e;

  localparam logic OP_ADD  = 1'b0;
  localparam logic OP_READ = 1'b1;

  // Bus-select and read-direction values for the cycle spent in a given state.
  function automatic logic state_drives_sel(state_e s);
    return (s == StClr) || (s == StWr) || (s == StRd);
  endfunction

  function automatic logic state_is_read(state_e s);
    return (s == StClr) || (s == StRd);
  endfunction

endpackage

// File: rtl/acc_bus_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter: on contention, grants the requester not granted last.
// The history bit updates only when advance is high and a grant is issued.
module rr_arbiter2 (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 1 means requester B (bit 1) won the most recent grant.
  logic r_last_b;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_last_b ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_last_b <= 1'b1;
    end else if (advance && (gnt != 2'b00)) begin
      r_last_b <= gnt[1];
    end
  end

endmodule

// File: rtl/acc_bus_ctrl.sv
// Shares one tri-state accumulator port between requesters A and B.
// Each grant becomes one ADD or READ-and-clear bus cycle; reads are followed by turnaround.
module acc_bus_ctrl
  import acc_bus_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             ReqA,
  input  logic             OpA,
  input  logic [WIDTH-1:0] DinA,
  input  logic             ReqB,
  input  logic             OpB,
  input  logic [WIDTH-1:0] DinB,
  output logic             AckA,
  output logic             AckB,
  output logic [WIDTH-1:0] RdData,
  output logic             Busy,
  output logic             Sel,
  output logic             RnW,
  inout  wire  [WIDTH-1:0] Dio
);

  localparam int unsigned CntW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [CntW-1:0] TurnLoad = CntW'(TURN_CYCLES - 1);

  state_e           r_state, w_state_d;
  logic             r_op, w_op_d;
  logic [WIDTH-1:0] r_operand, w_operand_d;
  logic             r_gnt_b, w_gnt_b_d;
  logic [CntW-1:0]  r_turn_cnt, w_turn_cnt_d;

  logic             r_sel, w_sel_d;
  logic             r_rnw, w_rnw_d;
  logic             r_busy, w_busy_d;
  logic             r_ack_a, w_ack_a_d;
  logic             r_ack_b, w_ack_b_d;
  logic [WIDTH-1:0] r_rd_data, w_rd_data_d;

  logic [1:0]       w_gnt;
  logic             w_advance;
  logic             w_bus_op;

  assign w_advance = (r_state == StIdle);

  rr_arbiter2 u_arb (
    .Clk     (Clk),
    .Rst     (Rst),
    .req     ({ReqB, ReqA}),
    .advance (w_advance),
    .gnt     (w_gnt)
  );

  always_comb begin
    w_state_d    = r_state;
    w_op_d       = r_op;
    w_operand_d  = r_operand;
    w_gnt_b_d    = r_gnt_b;
    w_turn_cnt_d = r_turn_cnt;
    unique case (r_state)
      StInit: w_state_d = StClr;
      StClr: begin
        w_state_d    = StTurn;
        w_turn_cnt_d = TurnLoad;
      end
      StTurn: begin
        if (r_turn_cnt == '0) begin
          w_state_d = StIdle;
        end else begin
          w_turn_cnt_d = r_turn_cnt - 1'b1;
        end
      end
      StIdle: begin
        if (w_gnt != 2'b00) begin
          w_gnt_b_d   = w_gnt[1];
          w_op_d      = w_gnt[1] ? OpB : OpA;
          w_operand_d = w_gnt[1] ? DinB : DinA;
          w_state_d   = (w_op_d == OP_READ) ? StRd : StWr;
        end
      end
      StWr: w_state_d = StIdle;
      StRd: begin
        w_state_d    = StTurn;
        w_turn_cnt_d = TurnLoad;
      end
      default: w_state_d = StInit;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  assign w_bus_op = (r_state == StWr) || (r_state == StRd);

  always_comb begin
    w_sel_d     = state_drives_sel(w_state_d);
    w_rnw_d     = state_is_read(w_state_d);
    w_busy_d    = (w_state_d != StIdle);
    w_ack_a_d   = w_bus_op && !r_gnt_b;
    w_ack_b_d   = w_bus_op && r_gnt_b;
    w_rd_data_d = (r_state == StRd) ? Dio : r_rd_data;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= StInit;
      r_op       <= OP_ADD;
      r_operand  <= '0;
      r_gnt_b    <= 1'b0;
      r_turn_cnt <= '0;
      r_sel      <= 1'b0;
      r_rnw      <= 1'b0;
      r_busy     <= 1'b1;
      r_ack_a    <= 1'b0;
      r_ack_b    <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_op       <= w_op_d;
      r_operand  <= w_operand_d;
      r_gnt_b    <= w_gnt_b_d;
      r_turn_cnt <= w_turn_cnt_d;
      r_sel      <= w_sel_d;
      r_rnw      <= w_rnw_d;
      r_busy     <= w_busy_d;
      r_ack_a    <= w_ack_a_d;
      r_ack_b    <= w_ack_b_d;
      r_rd_data  <= w_rd_data_d;
    end
  end

  assign Dio    = (r_sel && !r_rnw) ? r_operand : {WIDTH{1'bz}};
  assign Sel    = r_sel;
  assign RnW    = r_rnw;
  assign Busy   = r_busy;
  assign AckA   = r_ack_a;
  assign AckB   = r_ack_b;
  assign RdData = r_rd_data;

endmodule

// File: tb/tb_acc_bus_ctrl.sv
// Bench: controller plus a behavioural accumulator on the shared bus, two requester processes
// and a transaction-level model predicting grant order and read-back values.
module tb_acc_bus_ctrl;

  localparam int unsigned W = 8;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         ReqA = 1'b0, OpA = 1'b0, ReqB = 1'b0, OpB = 1'b0;
  logic [W-1:0] DinA = '0, DinB = '0;
  logic         AckA, AckB, Busy, Sel, RnW;
  logic [W-1:0] RdData;
  wire  [W-1:0] Dio;

  acc_bus_ctrl #(
    .WIDTH       (W),
    .TURN_CYCLES (1)
  ) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .ReqA   (ReqA),
    .OpA    (OpA),
    .DinA   (DinA),
    .ReqB   (ReqB),
    .OpB    (OpB),
    .DinB   (DinB),
    .AckA   (AckA),
    .AckB   (AckB),
    .RdData (RdData),
    .Busy   (Busy),
    .Sel    (Sel),
    .RnW    (RnW),
    .Dio    (Dio)
  );

  always #5 Clk = ~Clk;

  // Accumulator device: adds on write cycles, drives and clears on read cycles.
  logic [W-1:0] r_acc = '0;
  assign Dio = (Sel && RnW) ? r_acc : {W{1'bz}};
  always @(posedge Clk) begin
    if (Sel) r_acc <= RnW ? '0 : r_acc + Dio;
  end

  int n_cmp = 0;
  int n_err = 0;
  int sel_viol = 0;
  int ack_cnt = 0;
  logic prev_rd_sel = 1'b0;

  always @(negedge Clk) begin
    if (prev_rd_sel && Sel && !RnW) sel_viol++;
    prev_rd_sel = Sel && RnW;
    ack_cnt += int'(AckA) + int'(AckB);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transaction-level model state: accumulator contents and who won the last grant.
  int m_acc;
  bit m_last_b;
  bit q_op_a[$], q_op_b[$];
  int q_dat_a[$], q_dat_b[$];
  int exp_rd_a[$], exp_rd_b[$];
  bit exp_order[$], got_order[$];
  int lat_a, lat_b;

  task automatic push_op(input bit b, input bit op, input int d);
    if (b) begin q_op_b.push_back(op); q_dat_b.push_back(d); end
    else   begin q_op_a.push_back(op); q_dat_a.push_back(d); end
  endtask

  // Both requesters start together and re-request right after each Ack, so while both have
  // work the grants strictly alternate; afterwards the remaining requester runs alone.
  function automatic void model();
    int ia = 0;
    int ib = 0;
    bit pick;
    bit op;
    int d;
    exp_order.delete();
    got_order.delete();
    exp_rd_a.delete();
    exp_rd_b.delete();
    while (ia < q_op_a.size() || ib < q_op_b.size()) begin
      if (ia < q_op_a.size() && ib < q_op_b.size()) pick = !m_last_b;
      else pick = (ib < q_op_b.size());
      if (pick) begin op = q_op_b[ib]; d = q_dat_b[ib]; ib++; end
      else      begin op = q_op_a[ia]; d = q_dat_a[ia]; ia++; end
      if (op) begin
        if (pick) exp_rd_b.push_back(m_acc);
        else      exp_rd_a.push_back(m_acc);
        m_acc = 0;
      end else begin
        m_acc = (m_acc + d) % 256;
      end
      m_last_b = pick;
      exp_order.push_back(pick);
    end
  endfunction

  task automatic serve(input bit b);
    int n;
    n = b ? q_op_b.size() : q_op_a.size();
    for (int i = 0; i < n; i++) begin
      bit op;
      int d;
      int waited;
      bit got;
      int exp;
      op = b ? q_op_b[i] : q_op_a[i];
      d  = b ? q_dat_b[i] : q_dat_a[i];
      if (b) begin ReqB = 1'b1; OpB = op; DinB = W'(d); end
      else   begin ReqA = 1'b1; OpA = op; DinA = W'(d); end
      waited = 0;
      got = 1'b0;
      while (!got && waited < 64) begin
        @(posedge Clk); #1;
        waited++;
        got = b ? AckB : AckA;
      end
      if (!got) begin
        check(b ? "ack_timeout_b" : "ack_timeout_a", int'(got), 1);
        if (b) ReqB = 1'b0; else ReqA = 1'b0;
        return;
      end
      if (b) lat_b = waited; else lat_a = waited;
      got_order.push_back(b);
      if (op) begin
        exp = b ? exp_rd_b.pop_front() : exp_rd_a.pop_front();
        check(b ? "rd_data_b" : "rd_data_a", int'(RdData), exp);
      end
      if (b) ReqB = 1'b0; else ReqA = 1'b0;
      @(posedge Clk); #1;
    end
  endtask

  task automatic run_phase();
    int n;
    model();
    fork
      serve(1'b0);
      serve(1'b1);
    join
    check("order_len", got_order.size(), exp_order.size());
    n = (got_order.size() < exp_order.size()) ? got_order.size() : exp_order.size();
    for (int i = 0; i < n; i++) check("grant_order", int'(got_order[i]), int'(exp_order[i]));
    q_op_a.delete(); q_op_b.delete(); q_dat_a.delete(); q_dat_b.delete();
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    ReqA = 1'b0;
    ReqB = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_busy", int'(Busy), 1);
    check("rst_sel", int'(Sel), 0);
    check("rst_rnw", int'(RnW), 0);
    check("rst_ack", int'(AckA) + int'(AckB), 0);
    check("rst_rddata", int'(RdData), 0);
    Rst = 1'b0;
    @(posedge Clk); #1;
    check("clr_sel", int'(Sel), 1);
    check("clr_rnw", int'(RnW), 1);
    @(posedge Clk); #1;
    check("turn_sel", int'(Sel), 0);
    check("turn_busy", int'(Busy), 1);
    @(posedge Clk); #1;
    check("idle_busy", int'(Busy), 0);
    m_acc = 0;
    m_last_b = 1'b1;
  endtask

  initial begin
    int a0;
    do_reset();

    repeat (5) @(posedge Clk);
    #1;
    check("idle_busy_5", int'(Busy), 0);
    push_op(1'b0, 1'b1, 0);
    run_phase();
    check("read_latency", lat_a, 2);

    push_op(1'b0, 1'b0, 8'h05);
    push_op(1'b0, 1'b0, 8'h0A);
    push_op(1'b0, 1'b1, 0);
    push_op(1'b0, 1'b1, 0);
    run_phase();
    check("add_latency", lat_a, 2);

    push_op(1'b0, 1'b0, 8'hF0);
    push_op(1'b0, 1'b0, 8'h20);
    push_op(1'b0, 1'b1, 0);
    run_phase();

    do_reset();
    for (int i = 0; i < 2; i++) begin
      push_op(1'b0, 1'b0, 1);
      push_op(1'b1, 1'b0, 1);
    end
    run_phase();
    push_op(1'b0, 1'b1, 0);
    run_phase();

    push_op(1'b0, 1'b1, 0);
    push_op(1'b0, 1'b0, 8'h33);
    push_op(1'b0, 1'b1, 0);
    run_phase();

    // Reset while an ADD is on the bus: no Ack, bus released, clear sequence reruns.
    repeat (3) @(posedge Clk);
    #1;
    ReqA = 1'b1; OpA = 1'b0; DinA = 8'h44;
    @(posedge Clk); #1;
    check("t6_wr_sel", int'(Sel), 1);
    check("t6_wr_rnw", int'(RnW), 0);
    Rst = 1'b1;
    ReqA = 1'b0;
    a0 = ack_cnt;
    @(posedge Clk); #1;
    check("t6_sel_off", int'(Sel), 0);
    check("t6_busy", int'(Busy), 1);
    Rst = 1'b0;
    repeat (6) @(posedge Clk);
    #1;
    check("t6_no_ack", ack_cnt - a0, 0);
    check("t6_idle", int'(Busy), 0);
    m_acc = 0;
    m_last_b = 1'b1;
    push_op(1'b0, 1'b1, 0);
    run_phase();

    for (int r = 0; r < 10; r++) begin
      int na;
      int nb;
      na = $urandom_range(0, 5);
      nb = $urandom_range(0, 5);
      for (int i = 0; i < na; i++) push_op(1'b0, ($urandom_range(0, 3) == 0), $urandom_range(0, 255));
      for (int i = 0; i < nb; i++) push_op(1'b1, ($urandom_range(0, 3) == 0), $urandom_range(0, 255));
      run_phase();
    end
    push_op(1'b1, 1'b1, 0);
    run_phase();

    check("sel_read_then_write", sel_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
